// File: rtl/core_tstate.sv
// Machine-cycle / T-state sequencer for the 8085-compatible core: opcode fetch,
// memory/I-O read and write cycles, wait states, halt, and register-file strobes.
module core_tstate #(
    parameter int INSTSIZE = 13
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [INSTSIZE-1:0] chk_inst,
    input  logic                ready,
    output logic                enb_code,
    output logic                enb_data,
    output logic                enb_rreg,
    output logic                enb_wreg,
    output logic                ale,
    output logic                rd_n,
    output logic                wr_n,
    output logic                iom,
    output logic                s1,
    output logic                s0,
    output logic                pc_inc,
    output logic [2:0]          tstate,
    output logic [3:0]          mcycle,
    output logic                halted
);

    localparam int GO6    = 0;
    localparam int DAD    = 1;
    localparam int HLT    = 2;
    localparam int DIO    = 3;
    localparam int CYC_LO = 4;
    localparam int RW_LO  = 8;
    localparam int CCC    = 12;

    typedef enum logic [3:0] {
        S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef struct packed {
        logic       ale;
        logic       rd_n;
        logic       wr_n;
        logic       iom;
        logic       s1;
        logic       s0;
        logic       enb_code;
        logic       enb_data;
        logic       enb_rreg;
        logic       enb_wreg;
        logic       pc_inc;
        logic       halted;
        logic [2:0] tstate;
        logic [3:0] mcycle;
    } outs_t;

    state_t     state, state_nx;
    logic       m1, m1_nx;
    logic [3:0] idx, idx_nx, idx_inc;
    logic [3:0] cnt, cnt_nx;
    logic       pend_wb, pend_nx;
    logic [3:0] cyc_f;
    logic       wb_f;
    outs_t      outs;
    logic       unused_ccc;

    // Conditional cycles are already folded into CYC/RW by the decoder.
    assign unused_ccc = chk_inst[CCC];
    assign cyc_f      = chk_inst[CYC_LO +: 4];
    assign wb_f       = ~(chk_inst[GO6] | chk_inst[DAD] | chk_inst[HLT] | chk_inst[DIO])
                        & (chk_inst[RW_LO +: 4] == 4'd0);
    assign idx_inc    = idx + 4'd1;

    // Outputs are decoded from the state being entered, then registered.
    function automatic outs_t decode(input state_t s, input logic m, input logic [3:0] i,
                                     input logic [3:0] n, input logic pw,
                                     input logic [INSTSIZE-1:0] inst);
        outs_t      o;
        logic [3:0] rw;
        logic       wr_cyc;
        o      = '0;
        o.rd_n = 1'b1;
        o.wr_n = 1'b1;
        rw     = inst[RW_LO +: 4];
        wr_cyc = !m && (i < 4'd4) && rw[i[1:0]];
        case (s)
            S_IDLE: ;
            S_HALT: o.halted = 1'b1;
            default: begin
                o.mcycle = m ? 4'd1 : i + 4'd2;
                o.s1     = m | !wr_cyc;
                o.s0     = m | wr_cyc;
                o.iom    = !m && inst[DIO] && (i == n - 4'd1);
                case (s)
                    S_T1: begin
                        o.tstate   = 3'd1;
                        o.ale      = 1'b1;
                        o.enb_rreg = m & pw;
                        o.enb_wreg = m & pw;
                    end
                    S_T2, S_TW, S_T3: begin
                        o.tstate = (s == S_T2) ? 3'd2 : (s == S_TW) ? 3'd7 : 3'd3;
                        if (wr_cyc) begin
                            o.wr_n     = 1'b0;
                            o.enb_rreg = 1'b1;
                        end else begin
                            o.rd_n     = 1'b0;
                            o.pc_inc   = (s == S_T2);
                            o.enb_code = (s == S_T3) & m;
                            o.enb_data = (s == S_T3) & !m;
                        end
                    end
                    S_T4:    o.tstate = 3'd4;
                    S_T5:    o.tstate = 3'd5;
                    default: o.tstate = 3'd6;
                endcase
            end
        endcase
        return o;
    endfunction

    always_comb begin
        state_nx = state;
        m1_nx    = m1;
        idx_nx   = idx;
        cnt_nx   = cnt;
        pend_nx  = pend_wb;
        case (state)
            S_IDLE: begin
                state_nx = S_T1;
                m1_nx    = 1'b1;
            end
            S_T1: begin
                state_nx = S_T2;
                if (m1) pend_nx = 1'b0;
            end
            S_T2, S_TW: state_nx = ready ? S_T3 : S_TW;
            S_T3: begin
                state_nx = m1 ? S_T4 : S_T1;
                if (!m1) begin
                    idx_nx = idx_inc;
                    m1_nx  = (idx_inc == cnt);
                end
            end
            S_T4, S_T6: begin
                if (state == S_T4 && chk_inst[HLT]) begin
                    state_nx = S_HALT;
                    m1_nx    = 1'b0;
                    pend_nx  = 1'b0;
                end else if (state == S_T4 && chk_inst[GO6]) begin
                    state_nx = S_T5;
                end else begin
                    state_nx = S_T1;
                    cnt_nx   = cyc_f;
                    idx_nx   = 4'd0;
                    pend_nx  = wb_f;
                    m1_nx    = (cyc_f == 4'd0);
                end
            end
            S_T5:    state_nx = S_T6;
            default: state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            m1      <= 1'b0;
            idx     <= 4'd0;
            cnt     <= 4'd0;
            pend_wb <= 1'b0;
            outs    <= decode(S_IDLE, 1'b0, 4'd0, 4'd0, 1'b0, '0);
        end else begin
            state   <= state_nx;
            m1      <= m1_nx;
            idx     <= idx_nx;
            cnt     <= cnt_nx;
            pend_wb <= pend_nx;
            outs    <= decode(state_nx, m1_nx, idx_nx, cnt_nx, pend_nx, chk_inst);
        end
    end

    assign ale      = outs.ale;
    assign rd_n     = outs.rd_n;
    assign wr_n     = outs.wr_n;
    assign iom      = outs.iom;
    assign s1       = outs.s1;
    assign s0       = outs.s0;
    assign enb_code = outs.enb_code;
    assign enb_data = outs.enb_data;
    assign enb_rreg = outs.enb_rreg;
    assign enb_wreg = outs.enb_wreg;
    assign pc_inc   = outs.pc_inc;
    assign halted   = outs.halted;
    assign tstate   = outs.tstate;
    assign mcycle   = outs.mcycle;

endmodule

// File: tb/tb_core_tstate.sv
// Directed bench for core_tstate: fetch, read/write extra cycles, wait states,
// GO6, I/O cycles, halt and asynchronous reset.
module tb_core_tstate;

    logic        clk = 1'b0;
    logic        rstn;
    logic [12:0] chk_inst;
    logic        ready;
    logic        enb_code, enb_data, enb_rreg, enb_wreg;
    logic        ale, rd_n, wr_n, iom, s1, s0, pc_inc, halted;
    logic [2:0]  tstate;
    logic [3:0]  mcycle;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [12:0] OP_MOV_BC = 13'h000;
    localparam logic [12:0] OP_MOV_AM = 13'h010;
    localparam logic [12:0] OP_MOV_MA = 13'h110;
    localparam logic [12:0] OP_INX_B  = 13'h001;
    localparam logic [12:0] OP_OUT    = 13'h228;
    localparam logic [12:0] OP_HLT    = 13'h004;

    core_tstate #(.INSTSIZE(13)) dut (
        .clk(clk), .rstn(rstn), .chk_inst(chk_inst), .ready(ready),
        .enb_code(enb_code), .enb_data(enb_data), .enb_rreg(enb_rreg), .enb_wreg(enb_wreg),
        .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .iom(iom), .s1(s1), .s0(s0),
        .pc_inc(pc_inc), .tstate(tstate), .mcycle(mcycle), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pcs;
        int len;
        rstn     = 1'b0;
        ready    = 1'b1;
        chk_inst = OP_MOV_BC;
        repeat (3) step();
        chk("rst_tstate", tstate, 0);
        chk("rst_mcycle", mcycle, 0);
        chk("rst_strobes", {ale, rd_n, wr_n, iom, s1, s0, pc_inc, halted}, 8'b0110_0000);
        chk("rst_enb", {enb_code, enb_data, enb_rreg, enb_wreg}, 4'b0000);

        #3 rstn = 1'b1;
        step();
        chk("m1_t1_state", {mcycle, 1'b0, tstate}, {4'd1, 1'b0, 3'd1});
        chk("m1_t1_pins", {ale, s1, s0, iom, enb_wreg}, 5'b11100);
        step();
        chk("m1_t2", {tstate, rd_n, pc_inc}, {3'd2, 1'b0, 1'b1});
        step();
        chk("m1_t3", {tstate, rd_n, enb_code, pc_inc}, {3'd3, 1'b0, 1'b1, 1'b0});
        step();
        chk("m1_t4", {tstate, rd_n, enb_code}, {3'd4, 1'b1, 1'b0});
        step();
        chk("movbc_wb", {tstate, mcycle, enb_rreg, enb_wreg}, {3'd1, 4'd1, 1'b1, 1'b1});

        chk_inst = OP_MOV_AM;
        step();
        chk("wb_one_clk", {enb_rreg, enb_wreg}, 2'b00);
        repeat (3) step();
        chk("movam_m2_t1", {mcycle, tstate, ale, s1, s0, enb_wreg}, {4'd2, 3'd1, 4'b1100});
        step();
        chk("movam_m2_t2", {tstate, rd_n, wr_n, pc_inc}, {3'd2, 3'b011});
        step();
        chk("movam_m2_t3", {tstate, rd_n, enb_data, mcycle}, {3'd3, 2'b01, 4'd2});
        step();
        chk("movam_wb", {mcycle, tstate, enb_rreg, enb_wreg}, {4'd1, 3'd1, 2'b11});

        chk_inst = OP_MOV_MA;
        repeat (4) step();
        chk("movma_m2_t1", {mcycle, s1, s0}, {4'd2, 2'b01});
        step();
        chk("movma_m2_t2", {wr_n, rd_n, enb_rreg, pc_inc}, 4'b0110);
        step();
        chk("movma_m2_t3", {tstate, wr_n, enb_rreg}, {3'd3, 2'b01});
        step();
        chk("movma_no_wb", {mcycle, tstate, enb_rreg, enb_wreg}, {4'd1, 3'd1, 2'b00});

        chk_inst = OP_MOV_BC;
        ready    = 1'b0;
        pcs      = 0;
        step();
        pcs += pc_inc;
        chk("ws_t2", {tstate, rd_n}, {3'd2, 1'b0});
        step();
        pcs += pc_inc;
        chk("ws_tw1", {tstate, rd_n, mcycle, s1, s0}, {3'd7, 1'b0, 4'd1, 2'b11});
        step();
        pcs += pc_inc;
        chk("ws_tw2", {tstate, rd_n}, {3'd7, 1'b0});
        ready = 1'b1;
        step();
        pcs += pc_inc;
        chk("ws_t3", {tstate, rd_n, enb_code}, {3'd3, 2'b01});
        chk("ws_pc_inc_once", pcs, 1);
        len = 4;
        while (tstate != 3'd1 && len < 20) begin
            step();
            len++;
        end
        chk("ws_m1_len", len, 6);
        chk("ws_wb", {enb_rreg, enb_wreg}, 2'b11);

        chk_inst = OP_INX_B;
        repeat (4) step();
        chk("go6_t5", tstate, 5);
        step();
        chk("go6_t6", {tstate, mcycle}, {3'd6, 4'd1});
        step();
        chk("go6_next_m1", {tstate, mcycle, enb_wreg, enb_rreg}, {3'd1, 4'd1, 2'b00});

        chk_inst = OP_OUT;
        repeat (4) step();
        chk("io_m2_t1", {mcycle, s1, s0, iom}, {4'd2, 3'b100});
        repeat (3) step();
        chk("io_m3_t1", {mcycle, s1, s0, iom}, {4'd3, 3'b011});
        step();
        chk("io_m3_t2", {wr_n, iom}, 2'b01);
        repeat (2) step();
        chk("io_next_m1", {mcycle, tstate, iom, enb_wreg}, {4'd1, 3'd1, 2'b00});

        chk_inst = OP_HLT;
        repeat (4) step();
        chk("hlt_entry", {halted, tstate, mcycle, s1, s0, rd_n, wr_n, ale},
            {1'b1, 3'd0, 4'd0, 5'b00110});
        for (int k = 0; k < 20; k++) begin
            step();
            chk("hlt_hold", {halted, tstate, rd_n, wr_n}, {1'b1, 3'd0, 2'b11});
        end

        #2 rstn = 1'b0;
        #1;
        chk("async_rst", {halted, tstate, mcycle}, 8'd0);
        chk_inst = OP_MOV_BC;
        #4 rstn = 1'b1;
        step();
        chk("post_rst_t1", {halted, tstate, mcycle, enb_wreg}, {1'b0, 3'd1, 4'd1, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
